frame_reception: RTL and testbench

Byte-wide Ethernet MAC receive path, the receive-side counterpart of the MAC transmitter.
- Input is a GMII-style byte stream.
- Hunts for preamble and SFD, captures the destination, source and EtherType header fields, and filters on destination address.
- Streams the payload downstream with the FCS stripped, checks CRC-32, and reports per-frame status.
- Sits between the PHY-side byte interface and the receive buffer.

---
 rtl/frame_reception_if.sv | 32 +++
 rtl/frame_reception.sv | 219 +++++++++++++++++++++
 tb/tb_frame_reception.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_reception_if.sv
// PHY-side byte stream and receive-path results of the Ethernet MAC receiver.
// master = PHY / upstream side, slave = frame_reception.
interface frame_reception_if;
    logic [7:0]  rx_data;
    logic        rx_dv;
    logic        rx_er;
    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic        hdr_valid;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        addr_match;

    modport master (
        output rx_data, rx_dv, rx_er,
        input  dest_addr, src_addr, eth_type, hdr_valid,
        input  pl_data, pl_valid,
        input  frame_done, frame_ok, crc_err, len_err, addr_match
    );

    modport slave (
        input  rx_data, rx_dv, rx_er,
        output dest_addr, src_addr, eth_type, hdr_valid,
        output pl_data, pl_valid,
        output frame_done, frame_ok, crc_err, len_err, addr_match
    );
endinterface

// File: rtl/frame_reception.sv
// Byte-wide Ethernet MAC receive path: preamble/SFD hunt, header capture,
// destination filter, FCS-stripped payload streaming and CRC-32 status.
module frame_reception #(
    parameter logic [47:0] MAC_ADDR  = 48'hAABB_CCDD_EEFF,
    parameter bit          PROMISC   = 1'b0,
    parameter int unsigned PRE_MIN   = 7,
    parameter int unsigned MAX_FRAME = 1518
) (
    input logic              clk,
    input logic              rst_n,
    frame_reception_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        WAIT_END
    } state_t;

    localparam logic [3:0]  PRE_MIN_L = 4'(PRE_MIN);
    localparam logic [10:0] MAX_L     = 11'(MAX_FRAME);
    localparam logic [31:0] RESIDUE   = 32'hDEBB_20E3;

    state_t      state, state_next;
    logic [3:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [7:0]  dly [4];
    logic [47:0] dest_sh;
    logic [47:0] src_sh;
    logic [7:0]  type_hi;
    logic        addr_hit;
    logic        er_seen;

    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic        hdr_valid;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        addr_match;

    logic        sfd_hit;
    logic        end_hit;
    logic        post_sfd;
    logic        emit;
    logic        hdr_load;
    logic        addr_eval;
    logic        len_bad;
    logic [47:0] dest_full;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sfd_hit    = 1'b0;
        end_hit    = 1'b0;
        post_sfd   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_dv) state_next = (bus.rx_data == 8'h55) ? PREAMBLE : WAIT_END;
            end
            PREAMBLE: begin
                if (!bus.rx_dv) begin
                    state_next = IDLE;
                end else if (bus.rx_data == 8'h55) begin
                    state_next = PREAMBLE;
                end else if (bus.rx_data == 8'hD5 && pre_cnt >= PRE_MIN_L) begin
                    state_next = HEADER;
                    sfd_hit    = 1'b1;
                end else begin
                    state_next = WAIT_END;
                end
            end
            HEADER: begin
                if (!bus.rx_dv) begin
                    end_hit    = 1'b1;
                    state_next = IDLE;
                end else begin
                    post_sfd = 1'b1;
                    if (byte_cnt == 11'd13) state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!bus.rx_dv) begin
                    end_hit    = 1'b1;
                    state_next = IDLE;
                end else begin
                    post_sfd = 1'b1;
                end
            end
            WAIT_END: begin
                if (!bus.rx_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // byte_cnt holds the index of the arriving byte; byte j releases byte j-4
    // from the delay line, which keeps the trailing FCS bytes from ever leaving.
    assign emit      = post_sfd && (state == PAYLOAD) && addr_hit &&
                       (byte_cnt >= 11'd18) && (byte_cnt < MAX_L);
    assign hdr_load  = post_sfd && (state == HEADER) && (byte_cnt == 11'd13);
    assign addr_eval = post_sfd && (state == HEADER) && (byte_cnt == 11'd5);
    assign dest_full = {dest_sh[39:0], bus.rx_data};
    assign len_bad   = (byte_cnt < 11'd64) || (byte_cnt > MAX_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            byte_cnt   <= '0;
            crc        <= '1;
            for (int unsigned i = 0; i < 4; i++) dly[i] <= '0;
            dest_sh    <= '0;
            src_sh     <= '0;
            type_hi    <= '0;
            addr_hit   <= 1'b0;
            er_seen    <= 1'b0;
            dest_addr  <= '0;
            src_addr   <= '0;
            eth_type   <= '0;
            hdr_valid  <= 1'b0;
            pl_data    <= '0;
            pl_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            hdr_valid  <= 1'b0;
            pl_valid   <= 1'b0;
            frame_done <= 1'b0;

            if (state == IDLE && bus.rx_dv && bus.rx_data == 8'h55) begin
                pre_cnt <= 4'd1;
            end else if (state == PREAMBLE && bus.rx_dv && bus.rx_data == 8'h55 &&
                         pre_cnt != 4'hF) begin
                pre_cnt <= pre_cnt + 4'd1;
            end

            if (sfd_hit) begin
                byte_cnt <= '0;
                crc      <= '1;
                er_seen  <= 1'b0;
                addr_hit <= 1'b0;
            end

            if (post_sfd) begin
                if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
                crc    <= crc_byte(crc, bus.rx_data);
                dly[0] <= bus.rx_data;
                dly[1] <= dly[0];
                dly[2] <= dly[1];
                dly[3] <= dly[2];
                if (bus.rx_er) er_seen <= 1'b1;

                if (byte_cnt < 11'd6)       dest_sh <= dest_full;
                else if (byte_cnt < 11'd12) src_sh  <= {src_sh[39:0], bus.rx_data};
                else if (byte_cnt == 11'd12) type_hi <= bus.rx_data;

                if (addr_eval) begin
                    addr_hit <= PROMISC || (dest_full == MAC_ADDR) || (dest_full == '1);
                end

                if (hdr_load) begin
                    dest_addr <= dest_sh;
                    src_addr  <= src_sh;
                    eth_type  <= {type_hi, bus.rx_data};
                    hdr_valid <= 1'b1;
                end

                if (emit) begin
                    pl_data  <= dly[3];
                    pl_valid <= 1'b1;
                end
            end

            if (end_hit) begin
                frame_done <= 1'b1;
                crc_err    <= (crc != RESIDUE);
                len_err    <= len_bad;
                addr_match <= addr_hit;
                frame_ok   <= (crc == RESIDUE) && !len_bad && addr_hit && !er_seen;
            end
        end
    end

    assign bus.dest_addr  = dest_addr;
    assign bus.src_addr   = src_addr;
    assign bus.eth_type   = eth_type;
    assign bus.hdr_valid  = hdr_valid;
    assign bus.pl_data    = pl_data;
    assign bus.pl_valid   = pl_valid;
    assign bus.frame_done = frame_done;
    assign bus.frame_ok   = frame_ok;
    assign bus.crc_err    = crc_err;
    assign bus.len_err    = len_err;
    assign bus.addr_match = addr_match;

endmodule

// File: tb/tb_frame_reception.sv
// Directed bench for frame_reception: two instances (PROMISC 0 and 1) share one stimulus stream.
module tb_frame_reception;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_reception_if bus0 ();
    frame_reception_if bus1 ();

    assign bus1.rx_data = bus0.rx_data;
    assign bus1.rx_dv   = bus0.rx_dv;
    assign bus1.rx_er   = bus0.rx_er;

    frame_reception #(
        .MAC_ADDR(48'hAABB_CCDD_EEFF), .PROMISC(1'b0), .PRE_MIN(7), .MAX_FRAME(1518)
    ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    frame_reception #(
        .MAC_ADDR(48'hAABB_CCDD_EEFF), .PROMISC(1'b1), .PRE_MIN(7), .MAX_FRAME(1518)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int tests = 0;
    int fails = 0;

    // Event monitor: records what the DUTs emit; all judgement is in the initial block.
    logic [7:0] pl_buf0 [8192];
    int pl_n0 = 0, fd_n0 = 0, hdr_n0 = 0, ok_n0 = 0;
    int pl_n1 = 0, fd_n1 = 0;

    always @(negedge clk) begin
        if (bus0.pl_valid) begin
            if (pl_n0 < 8192) pl_buf0[pl_n0] <= bus0.pl_data;
            pl_n0 <= pl_n0 + 1;
        end
        if (bus0.hdr_valid)  hdr_n0 <= hdr_n0 + 1;
        if (bus0.frame_done) fd_n0 <= fd_n0 + 1;
        if (bus0.frame_done && bus0.frame_ok) ok_n0 <= ok_n0 + 1;
        if (bus1.pl_valid)   pl_n1 <= pl_n1 + 1;
        if (bus1.frame_done) fd_n1 <= fd_n1 + 1;
    end

    int pl0_s, fd0_s, hdr0_s, ok0_s, pl1_s, fd1_s;
    logic [7:0] frm [$];

    task automatic snap();
        pl0_s = pl_n0; fd0_s = fd_n0; hdr0_s = hdr_n0; ok0_s = ok_n0;
        pl1_s = pl_n1; fd1_s = fd_n1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reflected CRC-32 over the first len bytes of frm, returned as the FCS value.
    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c;
        logic        fb;
        c = '1;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dest, input logic [47:0] src,
                         input logic [15:0] etype, input int npl);
        logic [31:0] f;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dest[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        for (int i = 0; i < npl; i++) frm.push_back(8'(i));
        f = fcs_of(frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(f[i*8 +: 8]);
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk); #1;
        bus0.rx_data = d;
        bus0.rx_dv   = dv;
        bus0.rx_er   = er;
    endtask

    task automatic send_pre(input int npre, input logic [7:0] sfd);
        for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
        drive(sfd, 1'b1, 1'b0);
    endtask

    task automatic send_bytes(input int from, input int upto, input int er_idx);
        for (int i = from; i < upto; i++) drive(frm[i], 1'b1, i == er_idx);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int npre, input logic [7:0] sfd);
        send_pre(npre, sfd);
        send_bytes(0, frm.size(), -1);
        send_idle(6);
    endtask

    function automatic int pl_bad(input int start, input int n, input int flip_idx);
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            e = (k == flip_idx) ? 8'hFF : 8'(k);
            if (pl_buf0[start + k] !== e) bad++;
        end
        return bad;
    endfunction

    function automatic logic [3:0] st0();
        return {bus0.frame_ok, bus0.crc_err, bus0.len_err, bus0.addr_match};
    endfunction

    initial begin
        bus0.rx_data = '0;
        bus0.rx_dv   = 1'b0;
        bus0.rx_er   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_dest", bus0.dest_addr, 0);
        check("rst_flags", {bus0.eth_type, bus0.src_addr[15:0], bus0.hdr_valid, bus0.pl_valid,
                            bus0.frame_done, st0()}, 0);
        rst_n = 1'b1;
        send_idle(2);

        // Good broadcast frame, 46-byte payload, n = 64
        build(48'hFFFF_FFFF_FFFF, 48'hAABB_CCDD_EEFF, 16'h0800, 46);
        snap();
        send_frame(7, 8'hD5);
        check("good_hdr_cnt", hdr_n0 - hdr0_s, 1);
        check("good_dest", bus0.dest_addr, 48'hFFFF_FFFF_FFFF);
        check("good_src", bus0.src_addr, 48'hAABB_CCDD_EEFF);
        check("good_type", bus0.eth_type, 16'h0800);
        check("good_pl_cnt", pl_n0 - pl0_s, 46);
        check("good_pl_data", pl_bad(pl0_s, 46, -1), 0);
        check("good_fd_cnt", fd_n0 - fd0_s, 1);
        check("good_status", st0(), 4'b1001);

        // Same frame, payload byte 5 corrupted after FCS generation
        frm[14 + 5] = 8'hFF;
        snap();
        send_frame(7, 8'hD5);
        check("bad_fcs_pl_cnt", pl_n0 - pl0_s, 46);
        check("bad_fcs_pl_data", pl_bad(pl0_s, 46, 5), 0);
        check("bad_fcs_status", st0(), 4'b0101);

        // Foreign destination: filtered on DUT0, accepted on promiscuous DUT1
        build(48'h0102_0304_0506, 48'hAABB_CCDD_EEFF, 16'h0800, 46);
        snap();
        send_frame(7, 8'hD5);
        check("filt_pl_cnt", pl_n0 - pl0_s, 0);
        check("filt_fd_cnt", fd_n0 - fd0_s, 1);
        check("filt_status", st0(), 4'b0000);
        check("prom_pl_cnt", pl_n1 - pl1_s, 46);
        check("prom_fd_cnt", fd_n1 - fd1_s, 1);
        check("prom_status", {bus1.frame_ok, bus1.crc_err, bus1.len_err, bus1.addr_match}, 4'b1001);

        // Preamble errors
        build(48'hFFFF_FFFF_FFFF, 48'hAABB_CCDD_EEFF, 16'h0800, 46);
        snap();
        send_frame(5, 8'hD5);
        check("short_pre_fd", fd_n0 - fd0_s, 0);
        check("short_pre_hdr", hdr_n0 - hdr0_s, 0);
        snap();
        send_frame(7, 8'h12);
        check("bad_sfd_fd", fd_n0 - fd0_s, 0);
        check("bad_sfd_pl", pl_n0 - pl0_s, 0);
        check("bad_sfd_hdr", hdr_n0 - hdr0_s, 0);
        snap();
        send_frame(8, 8'hD5);
        check("long_pre_fd", fd_n0 - fd0_s, 1);
        check("long_pre_ok", ok_n0 - ok0_s, 1);

        // Runt: 10 post-SFD bytes, ends inside the header
        snap();
        send_pre(7, 8'hD5);
        send_bytes(0, 10, -1);
        send_idle(6);
        check("runt_fd", fd_n0 - fd0_s, 1);
        check("runt_hdr", hdr_n0 - hdr0_s, 0);
        check("runt_pl", pl_n0 - pl0_s, 0);
        check("runt_len_ok", {bus0.len_err, bus0.frame_ok}, 2'b10);

        // Oversize: 1522 post-SFD bytes; bytes 14..1513 stream, the rest is suppressed
        build(48'hFFFF_FFFF_FFFF, 48'hAABB_CCDD_EEFF, 16'h0800, 1504);
        snap();
        send_frame(7, 8'hD5);
        check("over_pl_cnt", pl_n0 - pl0_s, 1500);
        check("over_pl_last", pl_buf0[pl0_s + 1499], 8'hDB);
        check("over_status", st0(), 4'b0011);

        // rx_er on one payload byte of an otherwise good frame
        build(48'hAABB_CCDD_EEFF, 48'h0011_2233_4455, 16'h86DD, 50);
        snap();
        send_pre(7, 8'hD5);
        send_bytes(0, frm.size(), 30);
        send_idle(6);
        check("er_pl_cnt", pl_n0 - pl0_s, 50);
        check("er_status", st0(), 4'b0001);
        check("er_type", bus0.eth_type, 16'h86DD);

        // Back-to-back good frames with a single idle cycle
        build(48'hFFFF_FFFF_FFFF, 48'hAABB_CCDD_EEFF, 16'h0800, 46);
        snap();
        send_pre(7, 8'hD5);
        send_bytes(0, frm.size(), -1);
        send_idle(1);
        send_frame(7, 8'hD5);
        check("b2b_fd", fd_n0 - fd0_s, 2);
        check("b2b_ok", ok_n0 - ok0_s, 2);
        check("b2b_pl", pl_n0 - pl0_s, 92);

        // Reset in the middle of the payload, remainder of that frame, then a good frame
        build(48'hAABB_CCDD_EEFF, 48'h0102_0304_0506, 16'h0806, 46);
        snap();
        send_pre(7, 8'hD5);
        send_bytes(0, 30, -1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_dest", bus0.dest_addr, 0);
        check("mid_rst_flags", {bus0.eth_type, bus0.src_addr[15:0], bus0.hdr_valid, bus0.pl_valid,
                                bus0.frame_done, st0()}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_bytes(30, frm.size(), -1);
        send_idle(6);
        check("mid_rst_tail_fd", fd_n0 - fd0_s, 0);
        snap();
        send_frame(7, 8'hD5);
        check("post_rst_fd", fd_n0 - fd0_s, 1);
        check("post_rst_status", st0(), 4'b1001);
        check("post_rst_src", bus0.src_addr, 48'h0102_0304_0506);
        check("post_rst_pl", pl_bad(pl0_s, 46, -1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
